// File: rtl/ecc_reg_file_scrub.sv
`default_nettype none
// ============================================================================
// Module   : ecc_reg_file_scrub
// Purpose  : SEC-DED protected register file with two corrected read ports,
//            a background scrubber that repairs single-bit upsets in place,
//            and a debug port that flips stored codeword bits.
// Revision : 1.0  initial release
// ============================================================================
module ecc_reg_file_scrub #(
    parameter  int DATA_W         = 32,
    parameter  int DEPTH          = 32,
    parameter  int SCRUB_INTERVAL = 64,
    parameter  int CNT_W          = 16,
    localparam int P              = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
    localparam int CW_W           = DATA_W + P + 1,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [AW-1:0]     raddr1_i,
    input  logic [AW-1:0]     raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              rerr1_sec_o,
    output logic              rerr2_sec_o,
    output logic              rerr1_ded_o,
    output logic              rerr2_ded_o,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              scrub_en_i,
    input  logic              inj_en_i,
    input  logic [AW-1:0]     inj_addr_i,
    input  logic [CW_W-1:0]   inj_mask_i,
    output logic              scrub_busy_o,
    output logic [CNT_W-1:0]  corr_cnt_o,
    output logic [CNT_W-1:0]  uncorr_cnt_o,
    output logic              uncorr_flag_o
);

    // Codeword bit 0 is overall parity; bits 1..c_NPOS are Hamming positions.
    localparam int c_NPOS = DATA_W + P;
    localparam int c_TW   = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(SCRUB_INTERVAL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_FIX   = 2'd2
    } state_t;

    typedef struct packed {
        logic [CW_W-1:0] cw;
        logic            sec;
        logic            ded;
    } dec_t;

    function automatic logic [P-1:0] f_syndrome(input logic [CW_W-1:0] cw);
        logic [P-1:0] s;
        s = '0;
        for (int pos = 1; pos <= c_NPOS; pos++) begin
            if (cw[pos]) s = s ^ P'(pos);
        end
        return s;
    endfunction

    function automatic logic [CW_W-1:0] f_encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        logic [P-1:0]    s;
        int              di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos <= c_NPOS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[di];
                di++;
            end
        end
        // Placing the data-only syndrome into the power-of-two slots zeroes it.
        s = f_syndrome(cw);
        for (int i = 0; i < P; i++) cw[1 << i] = s[i];
        cw[0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

    function automatic logic [DATA_W-1:0] f_extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        int                di;
        d  = '0;
        di = 0;
        for (int pos = 1; pos <= c_NPOS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[di] = cw[pos];
                di++;
            end
        end
        return d;
    endfunction

    function automatic dec_t f_decode(input logic [CW_W-1:0] cw);
        dec_t         r;
        logic [P-1:0] s;
        s     = f_syndrome(cw);
        r.cw  = cw;
        r.sec = 1'b0;
        r.ded = 1'b0;
        if (^cw) begin
            r.sec = 1'b1;
            if (s == '0) begin
                r.cw[0] = ~cw[0];
            end else if (int'(s) <= c_NPOS) begin
                r.cw[s] = ~cw[s];
            end else begin
                // Syndrome points outside the codeword: not a correctable pattern.
                r.sec = 1'b0;
                r.ded = 1'b1;
            end
        end else if (s != '0) begin
            r.ded = 1'b1;
        end
        return r;
    endfunction

    logic [CW_W-1:0]  r_mem [DEPTH];
    state_t           r_state;
    logic [AW-1:0]    r_ptr;
    logic [c_TW-1:0]  r_timer;
    logic [CW_W-1:0]  r_fix_cw;
    logic [CNT_W-1:0] r_corr;
    logic [CNT_W-1:0] r_uncorr;
    logic             r_flag;

    state_t           w_state_nxt;
    logic [AW-1:0]    w_ptr_nxt;
    logic [AW-1:0]    w_ptr_inc;
    logic [c_TW-1:0]  w_timer_nxt;
    logic             w_corr_inc;
    logic             w_uncorr_inc;
    dec_t             w_dec1;
    dec_t             w_dec2;
    dec_t             w_dec_s;
    logic             w_arch_wr;
    logic             w_inj_wr;
    logic             w_fix_wr;
    logic             w_fix_abort;
    logic             w_ptr_hit;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [CW_W-1:0]  w_wr_cw;

    assign w_dec1  = f_decode(r_mem[raddr1_i]);
    assign w_dec2  = f_decode(r_mem[raddr2_i]);
    assign w_dec_s = f_decode(r_mem[r_ptr]);

    always_comb begin
        rdata1_o    = f_extract(w_dec1.cw);
        rerr1_sec_o = w_dec1.sec;
        rerr1_ded_o = w_dec1.ded;
        rdata2_o    = f_extract(w_dec2.cw);
        rerr2_sec_o = w_dec2.sec;
        rerr2_ded_o = w_dec2.ded;
        if (raddr1_i == '0) begin
            rdata1_o    = '0;
            rerr1_sec_o = 1'b0;
            rerr1_ded_o = 1'b0;
        end
        if (raddr2_i == '0) begin
            rdata2_o    = '0;
            rerr2_sec_o = 1'b0;
            rerr2_ded_o = 1'b0;
        end
    end

    // Single physical write port: architectural write > injection > scrub fix.
    assign w_arch_wr   = we_i && (waddr_i != '0);
    assign w_inj_wr    = inj_en_i && !we_i && (inj_addr_i != '0);
    assign w_fix_wr    = (r_state == S_FIX) && !we_i && !inj_en_i;
    assign w_fix_abort = (r_state == S_FIX) && we_i && (waddr_i == r_ptr);
    assign w_ptr_hit   = (we_i && (waddr_i == r_ptr)) ||
                         (inj_en_i && !we_i && (inj_addr_i == r_ptr));
    assign w_ptr_inc   = (r_ptr == AW'(DEPTH - 1)) ? AW'(1) : r_ptr + 1'b1;

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_ptr;
        w_wr_cw   = r_fix_cw;
        if (w_arch_wr) begin
            w_wr_en   = 1'b1;
            w_wr_addr = waddr_i;
            w_wr_cw   = f_encode(wdata_i);
        end else if (w_inj_wr) begin
            w_wr_en   = 1'b1;
            w_wr_addr = inj_addr_i;
            w_wr_cw   = r_mem[inj_addr_i] ^ inj_mask_i;
        end else if (w_fix_wr) begin
            w_wr_en   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_cw;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_timer_nxt  = r_timer;
        w_corr_inc   = 1'b0;
        w_uncorr_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (scrub_en_i) begin
                    if (r_timer == c_TLAST) begin
                        w_timer_nxt = '0;
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (w_dec_s.sec) begin
                    w_corr_inc = 1'b1;
                    // A same-cycle update of this entry supersedes the repair.
                    if (w_ptr_hit) begin
                        w_ptr_nxt   = w_ptr_inc;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_FIX;
                    end
                end else begin
                    w_uncorr_inc = w_dec_s.ded;
                    w_ptr_nxt    = w_ptr_inc;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_FIX: begin
                if (w_fix_abort || w_fix_wr) begin
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state  <= S_IDLE;
            r_ptr    <= AW'(1);
            r_timer  <= '0;
            r_fix_cw <= '0;
            r_corr   <= '0;
            r_uncorr <= '0;
            r_flag   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_timer <= w_timer_nxt;
            if (r_state == S_CHECK) r_fix_cw <= w_dec_s.cw;
            if (w_corr_inc && (r_corr != '1)) r_corr <= r_corr + 1'b1;
            if (w_uncorr_inc) begin
                r_flag <= 1'b1;
                if (r_uncorr != '1) r_uncorr <= r_uncorr + 1'b1;
            end
        end
    end

    assign scrub_busy_o  = (r_state != S_IDLE);
    assign corr_cnt_o    = r_corr;
    assign uncorr_cnt_o  = r_uncorr;
    assign uncorr_flag_o = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_ecc_reg_file_scrub.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_reg_file_scrub
// Purpose  : Randomized scoreboard bench for ecc_reg_file_scrub with a
//            bit-flip-count reference model of the stored entries.
// Revision : 1.0  initial release
// ============================================================================
module tb_ecc_reg_file_scrub;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int SI     = 1;
    localparam int CNT_W  = 16;

    function automatic int calc_p(input int dw);
        int p;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    localparam int P    = calc_p(DATA_W);
    localparam int CW_W = DATA_W + P + 1;
    localparam int AW   = $clog2(DEPTH);

    localparam int K_READ = 0;
    localparam int K_BUSY = 1;
    localparam int K_CNT  = 2;

    logic              clk = 1'b0;
    logic              rstN;
    logic [AW-1:0]     raddr1, raddr2, waddr, inj_addr;
    logic [DATA_W-1:0] rdata1, rdata2, wdata;
    logic              sec1, sec2, ded1, ded2;
    logic              we, scrub_en, inj_en;
    logic [CW_W-1:0]   inj_mask;
    logic              busy;
    logic [CNT_W-1:0]  corr, uncorr;
    logic              flag;

    ecc_reg_file_scrub #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .SCRUB_INTERVAL(SI), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstN(rstN),
        .raddr1_i(raddr1), .raddr2_i(raddr2),
        .rdata1_o(rdata1), .rdata2_o(rdata2),
        .rerr1_sec_o(sec1), .rerr2_sec_o(sec2),
        .rerr1_ded_o(ded1), .rerr2_ded_o(ded2),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .scrub_en_i(scrub_en),
        .inj_en_i(inj_en), .inj_addr_i(inj_addr), .inj_mask_i(inj_mask),
        .scrub_busy_o(busy),
        .corr_cnt_o(corr), .uncorr_cnt_o(uncorr), .uncorr_flag_o(flag)
    );

    always #5 clk = ~clk;

    // Reference model: true data plus the set of codeword bits flipped since
    // the last clean write. Flip count 1 is correctable, 2 is detectable.
    logic [DATA_W-1:0] m_data [DEPTH];
    logic [CW_W-1:0]   m_mask [DEPTH];
    int                m_ptr, m_corr, m_uncorr;
    bit                m_flag;

    typedef struct {
        int                kind;
        int                port;
        logic [DATA_W-1:0] data;
        int                cls;
        int                corr;
        int                uncorr;
        bit                flag;
        bit                busy;
        string             name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    exp_t              mon_e;
    logic [DATA_W-1:0] mon_d;
    logic              mon_s, mon_dd;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            case (mon_e.kind)
                K_READ: begin
                    mon_d  = (mon_e.port == 1) ? rdata1 : rdata2;
                    mon_s  = (mon_e.port == 1) ? sec1 : sec2;
                    mon_dd = (mon_e.port == 1) ? ded1 : ded2;
                    if (mon_s !== (mon_e.cls == 1) || mon_dd !== (mon_e.cls == 2) ||
                        (mon_e.cls < 2 && mon_d !== mon_e.data)) begin
                        errors++;
                        $display("FAIL %s port%0d: got data=%h sec=%b ded=%b, expected data=%h sec=%b ded=%b",
                                 mon_e.name, mon_e.port, mon_d, mon_s, mon_dd,
                                 mon_e.data, mon_e.cls == 1, mon_e.cls == 2);
                    end
                end
                K_BUSY: begin
                    if (busy !== mon_e.busy) begin
                        errors++;
                        $display("FAIL %s busy: got %b, expected %b", mon_e.name, busy, mon_e.busy);
                    end
                end
                default: begin
                    if (corr !== CNT_W'(mon_e.corr) || uncorr !== CNT_W'(mon_e.uncorr) ||
                        flag !== mon_e.flag || busy !== mon_e.busy) begin
                        errors++;
                        $display("FAIL %s counters: got corr=%0d uncorr=%0d flag=%b busy=%b, expected corr=%0d uncorr=%0d flag=%b busy=%b",
                                 mon_e.name, corr, uncorr, flag, busy,
                                 mon_e.corr, mon_e.uncorr, mon_e.flag, mon_e.busy);
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_read(input int port, input int a, input string nm);
        exp_t e;
        e.kind = K_READ;
        e.port = port;
        e.name = nm;
        e.data = (a == 0) ? '0 : m_data[a];
        e.cls  = (a == 0) ? 0 : $countones(m_mask[a]);
        q.push_back(e);
    endtask

    task automatic rd(input int a1, input int a2, input string nm);
        raddr1 = AW'(a1);
        raddr2 = AW'(a2);
        exp_read(1, a1, nm);
        exp_read(2, a2, nm);
    endtask

    task automatic exp_busy(input bit b, input string nm);
        exp_t e;
        e.kind = K_BUSY;
        e.busy = b;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic exp_cnt(input string nm);
        exp_t e;
        e.kind   = K_CNT;
        e.corr   = m_corr;
        e.uncorr = m_uncorr;
        e.flag   = m_flag;
        e.busy   = 1'b0;
        e.name   = nm;
        q.push_back(e);
    endtask

    function automatic logic [CW_W-1:0] mk_mask(input int nb);
        logic [CW_W-1:0] m;
        int              b1, b2;
        m  = '0;
        b1 = $urandom_range(CW_W - 1, 0);
        m[b1] = 1'b1;
        if (nb == 2) begin
            b2 = b1;
            while (b2 == b1) b2 = $urandom_range(CW_W - 1, 0);
            m[b2] = 1'b1;
        end
        return m;
    endfunction

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        we = 1'b1; waddr = AW'(a); wdata = d;
        tick();
        we = 1'b0;
        if (a != 0) begin
            m_data[a] = d;
            m_mask[a] = '0;
        end
    endtask

    task automatic inj(input int a, input logic [CW_W-1:0] m);
        inj_en = 1'b1; inj_addr = AW'(a); inj_mask = m;
        tick();
        inj_en = 1'b0;
        if (a != 0) m_mask[a] = m_mask[a] ^ m;
    endtask

    task automatic ptr_adv();
        m_ptr = (m_ptr == DEPTH - 1) ? 1 : m_ptr + 1;
    endtask

    task automatic sat_inc(inout int c);
        if (c < (1 << CNT_W) - 1) c++;
    endtask

    // Unstalled scrub of n consecutive entries; cadence follows from flip count.
    task automatic scrub_entries(input int n, input string nm);
        int c;
        scrub_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            c = $countones(m_mask[m_ptr]);
            exp_busy(1'b0, {nm, " idle"});
            tick();
            exp_busy(1'b1, {nm, " check"});
            tick();
            if (c == 1) begin
                exp_busy(1'b1, {nm, " fix"});
                tick();
                sat_inc(m_corr);
                m_mask[m_ptr] = '0;
            end else if (c == 2) begin
                sat_inc(m_uncorr);
                m_flag = 1'b1;
            end
            ptr_adv();
        end
        scrub_en = 1'b0;
        exp_cnt({nm, " end"});
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_mask[i] = '0;
        end
        m_ptr = 1; m_corr = 0; m_uncorr = 0; m_flag = 1'b0;
    endtask

    task automatic rand_cycle();
        int              a1, a2, wa, ia;
        bit              dow, doi;
        logic [DATA_W-1:0] wd;
        logic [CW_W-1:0] m;
        a1  = $urandom_range(DEPTH - 1, 0);
        a2  = $urandom_range(DEPTH - 1, 0);
        rd(a1, a2, "rand_rd");
        dow = ($urandom_range(1, 0) == 1);
        wa  = $urandom_range(DEPTH - 1, 1);
        wd  = $urandom;
        doi = ($urandom_range(2, 0) == 0);
        ia  = $urandom_range(DEPTH - 1, 0);
        if (ia != 0 && m_mask[ia] != '0) doi = 1'b0;
        m   = mk_mask($urandom_range(2, 1));
        we = dow; waddr = AW'(wa); wdata = wd;
        inj_en = doi; inj_addr = AW'(ia); inj_mask = m;
        tick();
        we = 1'b0; inj_en = 1'b0;
        if (dow) begin
            m_data[wa] = wd;
            m_mask[wa] = '0;
        end
        if (doi && !dow && ia != 0) m_mask[ia] = m_mask[ia] ^ m;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d;
        logic [CW_W-1:0]   m;
        rstN = 1'b0; we = 1'b0; scrub_en = 1'b0; inj_en = 1'b0;
        raddr1 = '0; raddr2 = '0; waddr = '0; wdata = '0; inj_addr = '0; inj_mask = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;

        // Reset state
        exp_cnt("reset");
        for (int a = 0; a < DEPTH; a++) begin
            rd(a, DEPTH - 1 - a, "reset_rd");
            tick();
        end

        // Random writes, injections and reads with the scrubber off
        for (int i = 0; i < 200; i++) rand_cycle();
        for (int a = 1; a < DEPTH; a++) wr(a, $urandom);
        for (int a = 0; a < DEPTH; a += 2) begin
            rd(a, a + 1, "clean_rd");
            tick();
        end

        // SEC on x5, then scrub up to and including x5
        wr(5, 32'hDEADBEEF);
        m = '0; m[3] = 1'b1;
        inj(5, m);
        rd(5, 5, "x5_sec");
        tick();
        scrub_entries(5, "scrub_x5");
        rd(5, 4, "x5_repaired");
        tick();

        // DED on x7 is counted but left unchanged
        wr(7, 32'h0000_1234);
        m = '0; m[5] = 1'b1; m[20] = 1'b1;
        inj(7, m);
        rd(7, 6, "x7_ded");
        tick();
        scrub_entries(2, "scrub_x7");
        rd(7, 7, "x7_still_ded");
        tick();
        wr(7, 32'h0000_1234);

        // Fresh write to the entry in FIX aborts the write-back
        inj(9, mk_mask(1));
        scrub_entries(1, "scrub_x8");
        scrub_en = 1'b1;
        exp_busy(1'b0, "x9 idle");
        tick();
        exp_busy(1'b1, "x9 check");
        tick();
        scrub_en = 1'b0;
        we = 1'b1; waddr = AW'(9); wdata = 32'hA5A5A5A5;
        exp_busy(1'b1, "x9 fix");
        tick();
        we = 1'b0;
        m_data[9] = 32'hA5A5A5A5; m_mask[9] = '0;
        sat_inc(m_corr);
        ptr_adv();
        exp_cnt("x9 abort");
        rd(9, 9, "x9_fresh");
        tick();
        inj(10, mk_mask(1));
        scrub_entries(1, "scrub_x10");
        rd(10, 9, "x10_repaired");
        tick();

        // Writes to x3 stall FIX on x4 until released
        inj(4, mk_mask(1));
        scrub_entries(24, "scrub_to_x4");
        scrub_en = 1'b1;
        exp_busy(1'b0, "x4 idle");
        tick();
        exp_busy(1'b1, "x4 check");
        tick();
        scrub_en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            d = $urandom;
            we = 1'b1; waddr = AW'(3); wdata = d;
            exp_busy(1'b1, "x4 stalled");
            rd(4, 3, "x4_stall_rd");
            tick();
            m_data[3] = d;
        end
        we = 1'b0;
        exp_busy(1'b1, "x4 released");
        rd(4, 3, "x4_pre_fix");
        tick();
        m_mask[4] = '0;
        sat_inc(m_corr);
        ptr_adv();
        exp_cnt("x4 fixed");
        rd(4, 3, "x4_repaired");
        tick();

        // x0 ignores writes and injections
        wr(0, 32'hFFFF_FFFF);
        inj(0, mk_mask(1));
        rd(0, 0, "x0_zero");
        tick();

        // SEC in every entry, one full pass, pointer returns to start
        for (int a = 1; a < DEPTH; a++) inj(a, mk_mask(1));
        scrub_entries(DEPTH - 1, "full_pass");
        for (int a = 0; a < DEPTH; a += 2) begin
            rd(a, a + 1, "post_pass_rd");
            tick();
        end
        inj(m_ptr, mk_mask(1));
        scrub_entries(1, "ptr_wrap");

        // Asynchronous reset in the middle of a stalled FIX
        inj(m_ptr, mk_mask(1));
        scrub_en = 1'b1;
        tick();
        tick();
        scrub_en = 1'b0;
        we = 1'b1; waddr = AW'(2); wdata = 32'h1111_1111;
        #2 rstN = 1'b0;
        model_reset();
        exp_cnt("async_reset");
        rd(2, 6, "async_reset_rd");
        tick();
        we = 1'b0;
        rstN = 1'b1;
        inj(1, mk_mask(1));
        scrub_entries(1, "post_reset_x1");
        rd(1, 2, "post_reset_rd");
        tick();
        tick();

        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
